// File: rtl/vga_frame_reader.sv
// vga_frame_reader: 640x480@60 VGA timing generator that streams grayscale pixels from the read-back FIFO.
// Define VGA_TEST_PATTERN_EN to add the test_mode port and the 8-bar colour pattern.

module vga_frame_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_de,
    output logic [15:0]       vga_rgb,
    output logic              frame_start,
    output logic              underflow,
    input  logic              underflow_clr
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    typedef enum logic [1:0] {WAIT_DATA, STREAM, RECOVER} state_t;

    state_t        r_state;
    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic          r_hs_d1, r_vs_d1, r_de_d1, r_fs_d1, r_rd_d1;

    logic          w_h_last, w_v_last, w_frame_end, w_active;
    logic          w_hsync_raw, w_vsync_raw, w_due, w_tm;
    logic [7:0]    w_pix;
    logic [15:0]   w_pix_rgb;
    logic          w_unused_hi;

    assign w_h_last    = (r_hcnt == HW'(H_TOTAL - 1));
    assign w_v_last    = (r_vcnt == VW'(V_TOTAL - 1));
    assign w_frame_end = w_h_last && w_v_last;
    assign w_active    = (r_hcnt < HW'(H_ACTIVE)) && (r_vcnt < VW'(V_ACTIVE));
    assign w_hsync_raw = !((r_hcnt >= HW'(H_ACTIVE + H_FP)) && (r_hcnt < HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign w_vsync_raw = !((r_vcnt >= VW'(V_ACTIVE + V_FP)) && (r_vcnt < VW'(V_ACTIVE + V_FP + V_SYNC)));

`ifdef VGA_TEST_PATTERN_EN
    assign w_tm = test_mode;
`else
    assign w_tm = 1'b0;
`endif

    assign w_due       = (r_state == STREAM) && w_active && !w_tm;
    assign fifo_rd     = w_due && !fifo_empty;
    assign w_pix       = fifo_dout[7:0];
    assign w_pix_rgb   = {w_pix[7:3], w_pix[7:2], w_pix[7:3]};
    assign w_unused_hi = ^fifo_dout[DATA_W-1:8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_h_last) begin
            r_hcnt <= '0;
            r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
        end else begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

    // Frame-boundary decisions are taken on the last blanking cycle so the new
    // state is already in effect when the counters reach h=0,v=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= WAIT_DATA;
            underflow <= 1'b0;
        end else begin
            if (w_tm) begin
                r_state <= WAIT_DATA;
            end else begin
                case (r_state)
                    WAIT_DATA: if (w_frame_end && !fifo_empty) r_state <= STREAM;
                    STREAM:    if (w_due && fifo_empty)        r_state <= RECOVER;
                    RECOVER:   if (w_frame_end)                r_state <= fifo_empty ? WAIT_DATA : STREAM;
                    default:                                   r_state <= WAIT_DATA;
                endcase
            end
            if (w_due && fifo_empty) underflow <= 1'b1;
            else if (underflow_clr)  underflow <= 1'b0;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]  w_bar_idx, r_bar_idx;
    logic        r_bar_en;
    logic [15:0] w_bar_rgb;

    always_comb begin
        w_bar_idx = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (r_hcnt >= HW'(i * (H_ACTIVE / 8))) w_bar_idx = 3'(i);
        end
    end

    always_comb begin
        case (r_bar_idx)
            3'd0:    w_bar_rgb = 16'hFFFF;
            3'd1:    w_bar_rgb = 16'hFFE0;
            3'd2:    w_bar_rgb = 16'h07FF;
            3'd3:    w_bar_rgb = 16'h07E0;
            3'd4:    w_bar_rgb = 16'hF81F;
            3'd5:    w_bar_rgb = 16'hF800;
            3'd6:    w_bar_rgb = 16'h001F;
            default: w_bar_rgb = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bar_en  <= 1'b0;
            r_bar_idx <= '0;
        end else begin
            r_bar_en  <= w_tm && w_active;
            r_bar_idx <= w_bar_idx;
        end
    end
`endif

    // Stage 1 holds the counter-derived flags while the popped word is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs_d1     <= 1'b1;
            r_vs_d1     <= 1'b1;
            r_de_d1     <= 1'b0;
            r_fs_d1     <= 1'b0;
            r_rd_d1     <= 1'b0;
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            vga_de      <= 1'b0;
            frame_start <= 1'b0;
            vga_rgb     <= '0;
        end else begin
            r_hs_d1     <= w_hsync_raw;
            r_vs_d1     <= w_vsync_raw;
            r_de_d1     <= w_active;
            r_fs_d1     <= (r_hcnt == '0) && (r_vcnt == '0);
            r_rd_d1     <= fifo_rd;
            vga_hsync   <= r_hs_d1;
            vga_vsync   <= r_vs_d1;
            vga_de      <= r_de_d1;
            frame_start <= r_fs_d1;
`ifdef VGA_TEST_PATTERN_EN
            if (r_bar_en) vga_rgb <= w_bar_rgb;
            else          vga_rgb <= r_rd_d1 ? w_pix_rgb : '0;
`else
            vga_rgb     <= r_rd_d1 ? w_pix_rgb : '0;
`endif
        end
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader on shrunk timing; a frame-level reference model
// predicts pops, underflow and the pixel stream, a separate monitor checks the outputs.

module tb_vga_frame_reader;

    localparam int HA = 16;
    localparam int HFP = 2;
    localparam int HS = 4;
    localparam int HB = 3;
    localparam int VA = 6;
    localparam int VFP = 1;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HA + HFP + HS + HB;
    localparam int VT = VA + VFP + VS + VB;
    localparam int FT = HT * VT;
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [15:0] fifo_dout = '0;
    logic        underflow_clr = 1'b0;
    logic        fifo_rd, vga_hsync, vga_vsync, vga_de, frame_start, underflow;
    logic [15:0] vga_rgb;
`ifdef VGA_TEST_PATTERN_EN
    logic        test_mode = 1'b0;
`endif

    typedef struct {
        logic        hs, vs, de, fs;
        logic [15:0] rgb;
        int          h, v;
    } exp_t;

    exp_t        q[$];
    logic [15:0] mem[$];
    int          rd_ptr = 0, mptr = 0, errors = 0, checks = 0, h = 0, v = 0;
    bit          m_stream, m_uf, prev_empty, prev_tm, just_reset;
    bit          force_empty, clr, tm, mon_en;

    initial forever #5 clk = ~clk;

    vga_frame_reader #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB), .DATA_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout),
        .fifo_rd(fifo_rd),
        .vga_hsync(vga_hsync),
        .vga_vsync(vga_vsync),
        .vga_de(vga_de),
        .vga_rgb(vga_rgb),
        .frame_start(frame_start),
        .underflow(underflow),
        .underflow_clr(underflow_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d)", name, act, exp, h, v);
        end
    endtask

    // Monitor: the entry pushed two stimulus cycles ago is what the outputs now describe.
    initial forever begin
        exp_t e;
        logic [19:0] got, want;
        @(posedge clk);
        #2;
        if (mon_en && q.size() >= 2) begin
            e    = q.pop_front();
            got  = {vga_hsync, vga_vsync, vga_de, frame_start, vga_rgb};
            want = {e.hs, e.vs, e.de, e.fs, e.rgb};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL out h=%0d v=%0d: got hs=%b vs=%b de=%b fs=%b rgb=%h expected hs=%b vs=%b de=%b fs=%b rgb=%h",
                         e.h, e.v, got[19], got[18], got[17], got[16], got[15:0],
                         want[19], want[18], want[17], want[16], want[15:0]);
            end
        end
    end

    function automatic logic [15:0] gray(input logic [15:0] w);
        int p, r, g;
        p = int'(w[7:0]);
        r = p / 8;
        g = p / 4;
        return 16'(r * 2048 + g * 32 + r);
    endfunction

    // One pixel clock: drive inputs, run the model, check fifo_rd, serve the FIFO stub.
    task automatic step();
        exp_t e;
        bit act, rd_exp, uf_evt, pop;
        logic [15:0] px;
        chk("underflow", {31'd0, underflow}, {31'd0, m_uf});
        fifo_empty    = ((mem.size() - rd_ptr) == 0) || force_empty;
        underflow_clr = clr;
`ifdef VGA_TEST_PATTERN_EN
        test_mode     = tm;
`endif
        if (h == 0 && v == 0 && !just_reset && !m_stream) m_stream = !prev_empty && !prev_tm;
        if (tm) m_stream = 0;
        act = (h < HA) && (v < VA);
        rd_exp = 0;
        uf_evt = 0;
        px = '0;
        if (act && tm) begin
            px = BARS[h / (HA / 8)];
        end else if (act && m_stream) begin
            if (fifo_empty) begin
                uf_evt = 1;
                m_stream = 0;
            end else begin
                rd_exp = 1;
                px = (mptr < mem.size()) ? gray(mem[mptr]) : 16'hDEAD;
                mptr++;
            end
        end
        if (uf_evt)   m_uf = 1;
        else if (clr) m_uf = 0;
        e.hs  = !(h >= HA + HFP && h < HA + HFP + HS);
        e.vs  = !(v >= VA + VFP && v < VA + VFP + VS);
        e.de  = act;
        e.fs  = (h == 0 && v == 0);
        e.rgb = px;
        e.h   = h;
        e.v   = v;
        q.push_back(e);
        #1;
        chk("fifo_rd", {31'd0, fifo_rd}, {31'd0, rd_exp});
        pop = fifo_rd && !fifo_empty;
        prev_empty = fifo_empty;
        prev_tm = tm;
        just_reset = 0;
        h++;
        if (h == HT) begin
            h = 0;
            v = (v == VT - 1) ? 0 : v + 1;
        end
        @(posedge clk);
        #1;
        if (pop) begin
            fifo_dout = mem[rd_ptr];
            rd_ptr++;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int x, input int y);
        for (int i = 0; i < FT && !(h == x && v == y); i++) step();
    endtask

    task automatic next_frame();
        step();
        run_to(0, 0);
    endtask

    task automatic refill(input int n);
        for (int i = 0; i < n; i++) mem.push_back({8'($urandom), 8'(mem.size())});
    endtask

    task automatic do_reset();
        mon_en = 0;
        #2 rst = 1'b1;
        #1;
        chk("reset", {25'd0, fifo_rd, vga_hsync, vga_vsync, vga_de, frame_start, underflow, |vga_rgb},
                     {25'd0, 7'b0110000});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete();
        h = 0;
        v = 0;
        m_stream = 0;
        m_uf = 0;
        prev_empty = 1;
        prev_tm = 0;
        just_reset = 1;
        mon_en = 1;
    endtask

    initial begin
        int x, y;
        mon_en = 0;
        force_empty = 0;
        clr = 0;
        tm = 0;
        @(negedge clk);
        do_reset();
        run(2 * FT);
        chk("no_pops_empty", rd_ptr, 0);

        for (int i = 0; i < HA * VA; i++) mem.push_back(16'h00A5);
        do_reset();
        run(2 * FT);
        chk("pops_a5_frame", rd_ptr, HA * VA);
        run(FT);
        clr = 1;
        step();
        clr = 0;
        run(FT);

        refill(2 * HA * VA);
        next_frame();
        run(2 * FT);

        refill(2 * HA * VA);
        next_frame();
        clr = 1;
        step();
        clr = 0;
        x = $urandom_range(1, HA - 1);
        y = $urandom_range(0, VA - 1);
        run_to(x, y);
        force_empty = 1;
        clr = 1;
        step();
        clr = 0;
        step();
        force_empty = 0;
        next_frame();
        run(FT);

        refill(HA * VA);
        clr = 1;
        step();
        clr = 0;
        run_to(HA - 1, VA - 1);
        force_empty = 1;
        step();
        force_empty = 0;
        run(2);
        next_frame();
        run(FT);

        refill(2 * HA * VA);
        run($urandom_range(10, FT - 10));
        do_reset();
        run(2 * FT);

`ifdef VGA_TEST_PATTERN_EN
        refill(2 * HA * VA);
        tm = 1;
        run(FT + 5);
        tm = 0;
        next_frame();
        run(FT);
`endif

        chk("pop_count", rd_ptr, mptr);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
